frame_sync_lock: RTL and testbench



---
 rtl/frame_sync_lock.sv | 182 ++++++++++++++++++
 tb/tb_frame_sync_lock.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sync_lock.sv
// frame_sync_lock: word-aligned frame synchronizer with hunt/verify/lock FSM
// and flywheel tolerance. Forwards input data one cycle later, tagged with a
// start-of-frame pulse and the lock status.
//
// Optional feature macro: FRAME_SYNC_STATS_EN (adds sync_err_cnt/lock_loss_cnt)
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   din           input data word
//   din_valid     din is valid this cycle
//   dout          registered copy of din
//   dout_valid    registered copy of din_valid
//   sof           dout is a sync-slot word while locked
//   locked        frame lock status, aligned with dout
//   sync_err_cnt  (stats only) mismatching slot words seen while locked
//   lock_loss_cnt (stats only) LOCKED-to-HUNT transitions
module frame_sync_lock #(
  parameter int unsigned     WIDTH      = 10,
  parameter logic [WIDTH-1:0] CONST_VAL = WIDTH'(10'b1010111010),
  parameter int unsigned     FRAME_LEN  = 16,
  parameter int unsigned     LOCK_CNT   = 3,
  parameter int unsigned     UNLOCK_CNT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             sof,
  output logic             locked
`ifdef FRAME_SYNC_STATS_EN
  ,
  output logic [15:0]      sync_err_cnt,
  output logic [15:0]      lock_loss_cnt
`endif
);

  localparam int unsigned POS_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned HIT_W  = $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W = $clog2(UNLOCK_CNT + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [HIT_W-1:0]    hit_q, hit_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic                sof_d;
  logic                match;
  logic                slot;
`ifdef FRAME_SYNC_STATS_EN
  logic                err_inc;
  logic                loss_inc;
`endif

  assign match = din_valid && (din == CONST_VAL);
  // Expected sync slot: valid word arriving at the last frame position.
  assign slot  = din_valid && (pos_q == POS_W'(FRAME_LEN - 1));

  // Next-state and per-word decisions; idle cycles leave everything untouched.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    sof_d   = 1'b0;
`ifdef FRAME_SYNC_STATS_EN
    err_inc  = 1'b0;
    loss_inc = 1'b0;
`endif
    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (match) begin
            state_d = VERIFY;
            pos_d   = '0;
            hit_d   = HIT_W'(1);
          end
        end
        VERIFY: begin
          if (slot) begin
            pos_d = '0;
            if (match) begin
              hit_d = hit_q + HIT_W'(1);
              if (hit_q + HIT_W'(1) == HIT_W'(LOCK_CNT)) begin
                state_d = LOCK;
                miss_d  = '0;
                sof_d   = 1'b1;
              end
            end else begin
              // Failing slot word is not reconsidered as a new hunt candidate.
              state_d = HUNT;
              hit_d   = '0;
            end
          end else begin
            pos_d = pos_q + POS_W'(1);
          end
        end
        LOCK: begin
          if (slot) begin
            pos_d = '0;
            if (match) begin
              miss_d = '0;
              sof_d  = 1'b1;
            end else begin
`ifdef FRAME_SYNC_STATS_EN
              err_inc = 1'b1;
`endif
              if (miss_q + MISS_W'(1) == MISS_W'(UNLOCK_CNT)) begin
                state_d = HUNT;
                hit_d   = '0;
                miss_d  = '0;
`ifdef FRAME_SYNC_STATS_EN
                loss_inc = 1'b1;
`endif
              end else begin
                // Flywheel: tolerate the miss and keep the frame cadence.
                miss_d = miss_q + MISS_W'(1);
                sof_d  = 1'b1;
              end
            end
          end else begin
            pos_d = pos_q + POS_W'(1);
          end
        end
        default: begin
          state_d = HUNT;
          pos_d   = '0;
          hit_d   = '0;
          miss_d  = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HUNT;
      pos_q      <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sof        <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      dout       <= din;
      dout_valid <= din_valid;
      sof        <= sof_d;
      locked     <= (state_d == LOCK);
    end
  end

`ifdef FRAME_SYNC_STATS_EN
  // Saturating statistics counters, updated with locked.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_err_cnt  <= '0;
      lock_loss_cnt <= '0;
    end else begin
      if (err_inc && (sync_err_cnt != 16'hFFFF)) begin
        sync_err_cnt <= sync_err_cnt + 16'd1;
      end
      if (loss_inc && (lock_loss_cnt != 16'hFFFF)) begin
        lock_loss_cnt <= lock_loss_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_frame_sync_lock.sv
// Scoreboard bench for frame_sync_lock: the driver pushes the expected
// registered response of every cycle; a monitor pops and compares it.
module tb_frame_sync_lock;

  localparam int unsigned W  = 10;
  localparam int unsigned FL = 16;
  localparam int unsigned LC = 3;
  localparam int unsigned UC = 2;
  localparam logic [W-1:0] SYNC = 10'h2BA;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         sof;
  logic         locked;
`ifdef FRAME_SYNC_STATS_EN
  logic [15:0]  sync_err_cnt;
  logic [15:0]  lock_loss_cnt;
`endif

  always #5 clk = ~clk;

  frame_sync_lock #(
    .WIDTH      (W),
    .CONST_VAL  (SYNC),
    .FRAME_LEN  (FL),
    .LOCK_CNT   (LC),
    .UNLOCK_CNT (UC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .sof        (sof),
    .locked     (locked)
`ifdef FRAME_SYNC_STATS_EN
    ,
    .sync_err_cnt  (sync_err_cnt),
    .lock_loss_cnt (lock_loss_cnt)
`endif
  );

  typedef struct packed {
    logic [W-1:0] dout;
    logic         dv;
    logic         sof;
    logic         lk;
    logic [15:0]  err;
    logic [15:0]  loss;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;

  // Reference model: frame alignment tracked by the index of the accepted
  // sync word; a slot is any later valid word a whole number of frames away.
  int m_mode;   // 0 hunting, 1 verifying, 2 locked
  int m_idx;    // valid words seen since reset
  int m_anchor; // index of the accepted candidate sync word
  int m_hits;
  int m_miss;
  int m_err;
  int m_loss;

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_anchor = 0;
    m_hits = 0; m_miss = 0; m_err = 0; m_loss = 0;
  endtask

  task automatic model_word(input logic [W-1:0] d, output logic s);
    bit is_sync;
    bit at_slot;
    is_sync = (d == SYNC);
    at_slot = (m_mode != 0) && (((m_idx - m_anchor) % FL) == 0);
    s = 1'b0;
    if (m_mode == 0) begin
      if (is_sync) begin
        m_mode = 1; m_anchor = m_idx; m_hits = 1;
      end
    end else if (m_mode == 1) begin
      if (at_slot) begin
        if (is_sync) begin
          m_hits++;
          if (m_hits == LC) begin
            m_mode = 2; m_miss = 0; s = 1'b1;
          end
        end else begin
          m_mode = 0; m_hits = 0;
        end
      end
    end else begin
      if (at_slot) begin
        if (is_sync) begin
          m_miss = 0; s = 1'b1;
        end else begin
          m_miss++;
          if (m_err < 65535) m_err++;
          if (m_miss == UC) begin
            m_mode = 0; m_miss = 0; m_hits = 0;
            if (m_loss < 65535) m_loss++;
          end else begin
            s = 1'b1;
          end
        end
      end
    end
    m_idx++;
  endtask

  function automatic logic [W-1:0] rand_nonsync();
    logic [W-1:0] r;
    do r = W'($urandom); while (r == SYNC);
    return r;
  endfunction

  // Drive one cycle of inputs and queue the response expected after the edge.
  task automatic step(input logic r, input logic v, input logic [W-1:0] d);
    exp_t e;
    logic s;
    rst = r; din_valid = v; din = d;
    e = '0;
    if (r) begin
      model_reset();
    end else begin
      s = 1'b0;
      if (v) model_word(d, s);
      e.dout = d;
      e.dv   = v;
      e.sof  = s;
      e.lk   = (m_mode == 2);
      e.err  = 16'(m_err);
      e.loss = 16'(m_loss);
    end
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [W-1:0] d, input int max_gap);
    int g;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 1)) : 0;
    repeat (g) step(1'b0, 1'b0, W'($urandom));
    step(1'b0, 1'b1, d);
  endtask

  task automatic send_frame(input logic [W-1:0] first, input int max_gap);
    send_word(first, max_gap);
    for (int i = 1; i < FL; i++) send_word(rand_nonsync(), max_gap);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  exp_t me;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (sb.size() != 0) begin
      me = sb.pop_front();
      chk("dout",       16'(dout),       16'(me.dout));
      chk("dout_valid", 16'(dout_valid), 16'(me.dv));
      chk("sof",        16'(sof),        16'(me.sof));
      chk("locked",     16'(locked),     16'(me.lk));
`ifdef FRAME_SYNC_STATS_EN
      chk("sync_err_cnt",  sync_err_cnt,  me.err);
      chk("lock_loss_cnt", lock_loss_cnt, me.loss);
`endif
    end
  end

  initial begin
    model_reset();
    // Reset held with a valid sync word on the input.
    step(1'b1, 1'b1, SYNC);
    step(1'b1, 1'b1, SYNC);

    // Clean acquisition: syncs every frame, lock on word 32.
    for (int f = 0; f < 5; f++) send_frame(SYNC, 0);

    // Flywheel: one corrupted slot, a good one, then two corrupted -> unlock.
    send_frame(10'h000, 0);
    send_frame(SYNC, 0);
    send_frame(10'h000, 0);
    send_frame(10'h000, 0);
    send_frame(rand_nonsync(), 0);

    // False candidate: syncs at 0 and 5, bad slot at 16, relock from 20.
    step(1'b1, 1'b0, '0);
    send_word(SYNC, 0);
    for (int i = 1; i < 5; i++) send_word(rand_nonsync(), 0);
    send_word(SYNC, 0);
    for (int i = 6; i < 16; i++) send_word(rand_nonsync(), 0);
    send_word(10'h155, 0);
    for (int i = 17; i < 20; i++) send_word(rand_nonsync(), 0);
    for (int f = 0; f < 4; f++) send_frame(SYNC, 0);

    // Valid gaps of 1-3 idle cycles between words.
    step(1'b1, 1'b0, '0);
    for (int f = 0; f < 5; f++) send_frame(SYNC, 3);

    // Mid-lock reset, then fresh reacquisition.
    step(1'b1, 1'b1, SYNC);
    for (int f = 0; f < 4; f++) send_frame(SYNC, 1);

    // Randomized traffic: mostly periodic syncs with dropouts and stray syncs.
    step(1'b1, 1'b0, '0);
    for (int f = 0; f < 40; f++) begin
      send_word(($urandom_range(9, 0) < 8) ? SYNC : rand_nonsync(), 1);
      for (int i = 1; i < FL; i++)
        send_word(($urandom_range(9, 0) == 0) ? SYNC : rand_nonsync(), 1);
    end
    step(1'b0, 1'b0, '0);

    // Let the monitor drain the queue, bounded.
    for (int k = 0; k < 5 && sb.size() != 0; k++) @(negedge clk);
    chk("scoreboard_drain", 16'(sb.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
